mac_array: RTL and testbench
============================

# mac_array

Four-lane multiply-accumulate stage directly upstream of the write-back unit. It takes a stream of 8-bit input samples, each paired with four 7-bit coefficients, and accumulates one 17-bit dot product per lane. When a result set is complete it presents MU1..MU4 and pulses web, then holds the results stable while write-back drains them to RAM.

## Interface
- TERMS, 4: products accumulated per result set. Range 1..16.
- HOLD, 4: cycles after web during which no new set may start, matching the write-back drain time.

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  request a new result set; honoured only in IDLE
- in_valid  in  1  x_in/c_in carry a valid term
- x_in  in  8  unsigned input sample
- c_in  in  28  four unsigned 7-bit coefficients; lane k uses c_in[7k+6:7k], k=0..3
- in_ready  out  1  term accepted this cycle when in_valid=1
- busy  out  1  state != IDLE
- web  out  1  one-cycle pulse: MU1..MU4 hold a new result set
- MU1..MU4  out  17 each  results of lanes 0..3

## Operation
- States:
  - IDLE: waiting for start.
  - ACC: accepting terms.
  - DONE: emitting web; lasts 1 cycle.
  - HOLD: waiting out the write-back drain; lasts HOLD cycles.
- IDLE:
  - start=1 -> ACC.
  - Accumulators acc0..acc3 cleared to 0 on the same edge; term counter cleared to 0.
- ACC:
  - in_ready=1.
  - On each edge with in_valid=1, for every lane: acc_k <= acc_k + x_in*c_k. Product is 15 bits, zero-extended to 17; the sum wraps modulo 2^17.
  - Term counter increments on every accepted term.
  - When the accepted term is number TERMS, go to DONE on the same edge.
  - in_valid=0 stalls the block with no change to any state.
- DONE:
  - MU1..MU4 registers <= acc0..acc3 on the edge entering DONE, so web and the new values appear together.
  - web=1 for exactly this cycle. Next state is HOLD with the hold counter at 0.
- HOLD:
  - Counter increments every cycle. At HOLD-1 -> IDLE.
  - start is ignored.
  - MU1..MU4 are unchanged.
- MU1..MU4 change only on DONE entry. They keep their last values through IDLE and the next ACC, until the next DONE.
- A start in ACC, DONE or HOLD is ignored and is not queued.
- x_in/c_in are don't-care when in_valid=0 or in_ready=0.
- The product width cannot overflow 17 bits for TERMS<=4 (max 4*255*127=129540). Larger TERMS wraps without saturation or flag.

## Timing
- Reset values: state IDLE, accumulators 0, counters 0, MU1..MU4=0, web=0, in_ready=0, busy=0.
- in_ready, busy and web are decoded from registered state only. None depends combinationally on the inputs.
- Latency: start edge -> in_ready=1 next cycle. Last term edge -> web=1 next cycle, with MU valid in that cycle.
- Minimum period from start to next accepted start is 1+TERMS+1+HOLD cycles, i.e. 10 for the defaults with no stalls.
- Write-back samples MU1..MU4 in the web cycle and reads MU1 for up to HOLD following cycles. HOLD guarantees MU stays stable for that window.
- Asynchronous reset mid-operation: every register returns to its reset value immediately, and any partial sums are discarded. The first edge after reset release sees state IDLE.
- Simultaneous start and in_valid in IDLE: start is taken; the term is not accepted (in_ready=0 in IDLE).

## Test plan
- Reset: hold rst=0 while driving random inputs -> web=0, in_ready=0, busy=0, MU1..MU4=0. Release -> same values until start.
- Basic set: start, then 4 back-to-back terms, x=1,2,3,4 with all lanes c=10,20,30,40 -> one cycle after the 4th term, web=1 for 1 cycle and MU1..MU4=300 each.
- Lane independence and maximum value:
  - x=255 for 4 terms with c0=127, c1=0, c2=1, c3=64.
  - Required: MU1=129540, MU2=0, MU3=1020, MU4=65280.
- Stalls: same stimulus as the basic set with in_valid deasserted for 3 cycles between terms 2 and 3 -> identical MU values; web delayed by exactly 3 cycles.
- Ignored start:
  - Pulse start during ACC and during each HOLD cycle -> no restart, term count unaffected, MU stable for all 4 HOLD cycles.
  - Next start accepted only once busy=0.
- Reset mid-ACC after 2 terms:
  - Required: outputs return to reset values at once.
  - A subsequent full set yields results containing no residue from the aborted sums.

Source files
------------

// File: rtl/mac_array_if.sv
// Sample/coefficient stream into the MAC array and result set out to write-back.
// The master drives the term stream; the slave is the MAC array.
interface mac_array_if;
    logic        start;
    logic        in_valid;
    logic [7:0]  x_in;
    logic [27:0] c_in;
    logic        in_ready;
    logic        busy;
    logic        web;
    logic [16:0] MU1;
    logic [16:0] MU2;
    logic [16:0] MU3;
    logic [16:0] MU4;

    modport master (
        output start, in_valid, x_in, c_in,
        input  in_ready, busy, web, MU1, MU2, MU3, MU4
    );

    modport slave (
        input  start, in_valid, x_in, c_in,
        output in_ready, busy, web, MU1, MU2, MU3, MU4
    );
endinterface

// File: rtl/mac_array.sv
// Four-lane 8x7 multiply-accumulate producing one 17-bit dot product per lane per set.
// Results and web arrive one cycle after the last term; in_valid=0 stalls, starts outside IDLE are dropped.
module mac_array #(
    parameter int TERMS = 4,
    parameter int HOLD  = 4
) (
    input  logic        clk,
    input  logic        rst,
    mac_array_if.slave  bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    localparam int TCW = 5;
    localparam int HCW = 8;

    logic [1:0]     state;
    logic [TCW-1:0] term_cnt;
    logic [HCW-1:0] hold_cnt;
    logic [16:0]    acc     [4];
    logic [16:0]    acc_nxt [4];
    logic [16:0]    mu      [4];
    logic [14:0]    prod    [4];
    logic           take;
    logic           last_term;

    assign take      = (state == S_ACC) && bus.in_valid;
    assign last_term = take && (term_cnt == TCW'(TERMS - 1));

    // Products are zero-extended; the running sum wraps modulo 2^17.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            prod[k]    = 15'(bus.x_in) * 15'(bus.c_in[7*k +: 7]);
            acc_nxt[k] = acc[k] + {2'b00, prod[k]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            term_cnt <= '0;
            hold_cnt <= '0;
            for (int k = 0; k < 4; k++) begin
                acc[k] <= '0;
                mu[k]  <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state    <= S_ACC;
                        term_cnt <= '0;
                        for (int k = 0; k < 4; k++) acc[k] <= '0;
                    end
                end
                S_ACC: begin
                    if (take) begin
                        term_cnt <= term_cnt + 1'b1;
                        for (int k = 0; k < 4; k++) acc[k] <= acc_nxt[k];
                        // Capture the final sums directly so web and MU appear together.
                        if (last_term) begin
                            state <= S_DONE;
                            for (int k = 0; k < 4; k++) mu[k] <= acc_nxt[k];
                        end
                    end
                end
                S_DONE: begin
                    state    <= S_HOLD;
                    hold_cnt <= '0;
                end
                S_HOLD: begin
                    hold_cnt <= hold_cnt + 1'b1;
                    if (hold_cnt == HCW'(HOLD - 1)) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready = (state == S_ACC);
    assign bus.busy     = (state != S_IDLE);
    assign bus.web      = (state == S_DONE);
    assign bus.MU1      = mu[0];
    assign bus.MU2      = mu[1];
    assign bus.MU3      = mu[2];
    assign bus.MU4      = mu[3];

endmodule

// File: tb/tb_mac_array.sv
// Directed bench for mac_array: reset, basic set, lane maxima, stalls, ignored starts, reset abort.
module tb_mac_array;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mac_array_if bus ();

    mac_array #(.TERMS(4), .HOLD(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic w, input logic r, input logic b);
        chk({tag, ".web"},      {31'd0, bus.web},      {31'd0, w});
        chk({tag, ".in_ready"}, {31'd0, bus.in_ready}, {31'd0, r});
        chk({tag, ".busy"},     {31'd0, bus.busy},     {31'd0, b});
    endtask

    task automatic chk_mu(input string tag, input logic [16:0] m1, input logic [16:0] m2,
                          input logic [16:0] m3, input logic [16:0] m4);
        chk({tag, ".MU1"}, {15'd0, bus.MU1}, {15'd0, m1});
        chk({tag, ".MU2"}, {15'd0, bus.MU2}, {15'd0, m2});
        chk({tag, ".MU3"}, {15'd0, bus.MU3}, {15'd0, m3});
        chk({tag, ".MU4"}, {15'd0, bus.MU4}, {15'd0, m4});
    endtask

    function automatic logic [27:0] lanes(input logic [6:0] c3, input logic [6:0] c2,
                                          input logic [6:0] c1, input logic [6:0] c0);
        return {c3, c2, c1, c0};
    endfunction

    task automatic term(input logic [7:0] x, input logic [27:0] c);
        bus.in_valid = 1'b1;
        bus.x_in     = x;
        bus.c_in     = c;
        step();
        bus.in_valid = 1'b0;
        bus.x_in     = 8'($urandom);
        bus.c_in     = 28'($urandom);
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    // Called in the web cycle: checks web, the 4 HOLD cycles, and the return to IDLE.
    task automatic finish_set(input string tag, input logic [16:0] m1, input logic [16:0] m2,
                              input logic [16:0] m3, input logic [16:0] m4, input logic poke);
        chk_ctl({tag, ".done"}, 1'b1, 1'b0, 1'b1);
        chk_mu({tag, ".done"}, m1, m2, m3, m4);
        for (int i = 0; i < 4; i++) begin
            bus.start = poke;
            step();
            chk_ctl($sformatf("%s.hold%0d", tag, i), 1'b0, 1'b0, 1'b1);
            chk_mu($sformatf("%s.hold%0d", tag, i), m1, m2, m3, m4);
        end
        bus.start = poke;
        step();
        bus.start = 1'b0;
        chk_ctl({tag, ".idle"}, 1'b0, 1'b0, 1'b0);
        chk_mu({tag, ".idle"}, m1, m2, m3, m4);
    endtask

    task automatic basic_terms();
        term(8'd1, lanes(7'd10, 7'd10, 7'd10, 7'd10));
        term(8'd2, lanes(7'd20, 7'd20, 7'd20, 7'd20));
        term(8'd3, lanes(7'd30, 7'd30, 7'd30, 7'd30));
        term(8'd4, lanes(7'd40, 7'd40, 7'd40, 7'd40));
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.x_in     = '0;
        bus.c_in     = '0;

        // Reset held with random inputs toggling.
        for (int i = 0; i < 3; i++) begin
            bus.start    = 1'($urandom);
            bus.in_valid = 1'($urandom);
            bus.x_in     = 8'($urandom);
            bus.c_in     = 28'($urandom);
            step();
            chk_ctl("rst_hold", 1'b0, 1'b0, 1'b0);
            chk_mu("rst_hold", 17'd0, 17'd0, 17'd0, 17'd0);
        end
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        step();
        chk_ctl("rst_rel", 1'b0, 1'b0, 1'b0);
        chk_mu("rst_rel", 17'd0, 17'd0, 17'd0, 17'd0);

        // Basic set: 1*10+2*20+3*30+4*40 = 300 on every lane.
        do_start();
        chk_ctl("basic.acc", 1'b0, 1'b1, 1'b1);
        basic_terms();
        finish_set("basic", 17'd300, 17'd300, 17'd300, 17'd300, 1'b0);

        // Lane independence at the 17-bit maximum.
        do_start();
        for (int i = 0; i < 4; i++) term(8'd255, lanes(7'd64, 7'd1, 7'd0, 7'd127));
        finish_set("lanes", 17'd129540, 17'd0, 17'd1020, 17'd65280, 1'b0);

        // Three stall cycles between terms 2 and 3; web must not appear early.
        do_start();
        term(8'd1, lanes(7'd10, 7'd10, 7'd10, 7'd10));
        term(8'd2, lanes(7'd20, 7'd20, 7'd20, 7'd20));
        for (int i = 0; i < 3; i++) begin
            bus.x_in = 8'($urandom);
            bus.c_in = 28'($urandom);
            step();
            chk_ctl($sformatf("stall%0d", i), 1'b0, 1'b1, 1'b1);
            chk_mu($sformatf("stall%0d", i), 17'd129540, 17'd0, 17'd1020, 17'd65280);
        end
        term(8'd3, lanes(7'd30, 7'd30, 7'd30, 7'd30));
        chk_ctl("stall.t3", 1'b0, 1'b1, 1'b1);
        term(8'd4, lanes(7'd40, 7'd40, 7'd40, 7'd40));
        finish_set("stall", 17'd300, 17'd300, 17'd300, 17'd300, 1'b0);

        // Starts during ACC and every HOLD cycle are dropped; x sum 10 -> lanes 50,10,20,30.
        do_start();
        bus.start = 1'b1;
        term(8'd1, lanes(7'd3, 7'd2, 7'd1, 7'd5));
        step();
        bus.start = 1'b0;
        chk_ctl("ign.acc", 1'b0, 1'b1, 1'b1);
        term(8'd2, lanes(7'd3, 7'd2, 7'd1, 7'd5));
        term(8'd3, lanes(7'd3, 7'd2, 7'd1, 7'd5));
        chk_ctl("ign.t3", 1'b0, 1'b1, 1'b1);
        term(8'd4, lanes(7'd3, 7'd2, 7'd1, 7'd5));
        finish_set("ign", 17'd50, 17'd10, 17'd20, 17'd30, 1'b1);
        step();
        chk_ctl("ign.noqueue", 1'b0, 1'b0, 1'b0);

        // Start accepted once idle, then reset lands after two terms.
        do_start();
        chk_ctl("abort.acc", 1'b0, 1'b1, 1'b1);
        term(8'd200, lanes(7'd127, 7'd127, 7'd127, 7'd127));
        term(8'd200, lanes(7'd127, 7'd127, 7'd127, 7'd127));
        #2 rst = 1'b0;
        #1;
        chk_ctl("abort.rst", 1'b0, 1'b0, 1'b0);
        chk_mu("abort.rst", 17'd0, 17'd0, 17'd0, 17'd0);
        step();
        rst = 1'b1;

        // Simultaneous start and term in IDLE: only start is taken.
        bus.start    = 1'b1;
        bus.in_valid = 1'b1;
        bus.x_in     = 8'd100;
        bus.c_in     = lanes(7'd100, 7'd100, 7'd100, 7'd100);
        step();
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        chk_ctl("post.acc", 1'b0, 1'b1, 1'b1);
        basic_terms();
        finish_set("post", 17'd300, 17'd300, 17'd300, 17'd300, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
